// File: rtl/traffic_input_cond_if.sv
// traffic_input_cond_if: pin-side and controller-side signals of the
// input conditioner, with master (driver) and slave (conditioner) views.
interface traffic_input_cond_if;
    logic sample_en;
    logic btn_raw;
    logic sensor_raw;
    logic walk_ack;
    logic sensor;
    logic button_walk;
    logic btn_press;

    modport master (
        output sample_en,
        output btn_raw,
        output sensor_raw,
        output walk_ack,
        input  sensor,
        input  button_walk,
        input  btn_press
    );

    modport slave (
        input  sample_en,
        input  btn_raw,
        input  sensor_raw,
        input  walk_ack,
        output sensor,
        output button_walk,
        output btn_press
    );
endinterface

// File: rtl/traffic_input_cond.sv
// traffic_input_cond: synchronizes and debounces the walk button and
// side-street sensor, and latches walk requests until acknowledged.
module traffic_input_cond #(
    parameter int DB_COUNT = 4,
    parameter int CNT_W    = 3
) (
    input logic                 clk,
    input logic                 reset,
    traffic_input_cond_if.slave bus
);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic             r_btn_s0;
    logic             r_btn_s1;
    logic             r_sen_s0;
    logic             r_sen_s1;
    logic             r_btn_stb;
    logic             r_sen_stb;
    logic             r_btn_stb_q;
    logic [CNT_W-1:0] r_btn_cnt;
    logic [CNT_W-1:0] r_sen_cnt;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_btn_press;

    // Two-flop synchronizers for both raw pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s0 <= 1'b0;
            r_btn_s1 <= 1'b0;
            r_sen_s0 <= 1'b0;
            r_sen_s1 <= 1'b0;
        end else begin
            r_btn_s0 <= bus.btn_raw;
            r_btn_s1 <= r_btn_s0;
            r_sen_s0 <= bus.sensor_raw;
            r_sen_s1 <= r_sen_s0;
        end
    end

    // Button debounce: flip only after DB_COUNT differing strobes in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_stb <= 1'b0;
            r_btn_cnt <= '0;
        end else if (bus.sample_en) begin
            if (r_btn_s1 == r_btn_stb) begin
                r_btn_cnt <= '0;
            end else if (r_btn_cnt == LP_CNT_LAST) begin
                r_btn_stb <= r_btn_s1;
                r_btn_cnt <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + LP_CNT_ONE;
            end
        end
    end

    // Sensor debounce: same rule as the button channel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sen_stb <= 1'b0;
            r_sen_cnt <= '0;
        end else if (bus.sample_en) begin
            if (r_sen_s1 == r_sen_stb) begin
                r_sen_cnt <= '0;
            end else if (r_sen_cnt == LP_CNT_LAST) begin
                r_sen_stb <= r_sen_s1;
                r_sen_cnt <= '0;
            end else begin
                r_sen_cnt <= r_sen_cnt + LP_CNT_ONE;
            end
        end
    end

    // One-clock delay of the debounced button for rising-edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_stb_q <= 1'b0;
        end else begin
            r_btn_stb_q <= r_btn_stb;
        end
    end

    // Both terms are flops, so the press pulse is glitch-free
    assign w_btn_press = r_btn_stb & ~r_btn_stb_q;

    // Request FSM next state: a press in the ack cycle re-arms the request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_press) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (bus.walk_ack && !w_btn_press) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign bus.sensor      = r_sen_stb;
    assign bus.btn_press   = w_btn_press;
    assign bus.button_walk = (r_state == ST_PEND);
endmodule

// File: tb/tb_traffic_input_cond.sv
// tb_traffic_input_cond: directed test-plan steps plus a randomized run,
// all checked every cycle against a behavioural model.
module tb_traffic_input_cond;
    localparam int DBC = 4;

    logic clk;
    logic reset;

    traffic_input_cond_if bif ();

    traffic_input_cond #(
        .DB_COUNT(DBC),
        .CNT_W   (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // behavioural model
    bit m_btn_q[$];
    bit m_sen_q[$];
    bit m_btn_stb;
    bit m_btn_stb_q;
    bit m_sen_stb;
    int m_btn_run;
    int m_sen_run;
    bit m_pend;

    int n_press;
    int bw_seen;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic deb(input bit s1, inout bit stb, inout int run);
        if (s1 == stb) begin
            run = 0;
        end else if (run + 1 == DBC) begin
            stb = s1;
            run = 0;
        end else begin
            run = run + 1;
        end
    endtask

    task automatic model_edge();
        bit press_o;
        press_o = m_btn_stb & ~m_btn_stb_q;
        if (reset) begin
            m_btn_q     = '{1'b0, 1'b0};
            m_sen_q     = '{1'b0, 1'b0};
            m_btn_stb   = 1'b0;
            m_btn_stb_q = 1'b0;
            m_sen_stb   = 1'b0;
            m_btn_run   = 0;
            m_sen_run   = 0;
            m_pend      = 1'b0;
        end else begin
            m_pend      = press_o | (m_pend & ~bif.walk_ack);
            m_btn_stb_q = m_btn_stb;
            if (bif.sample_en) begin
                deb(m_btn_q[0], m_btn_stb, m_btn_run);
                deb(m_sen_q[0], m_sen_stb, m_sen_run);
            end
            m_btn_q.push_back(bif.btn_raw);
            void'(m_btn_q.pop_front());
            m_sen_q.push_back(bif.sensor_raw);
            void'(m_sen_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("sensor", int'(bif.sensor), int'(m_sen_stb));
        chk("button_walk", int'(bif.button_walk), int'(m_pend));
        chk("btn_press", int'(bif.btn_press),
            int'(m_btn_stb & ~m_btn_stb_q));
        n_press += int'(bif.btn_press);
        bw_seen |= int'(bif.button_walk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic strobe();
        bif.sample_en = 1'b1;
        tick();
        bif.sample_en = 1'b0;
    endtask

    initial begin
        int n;
        int first;
        bit seen;

        m_btn_q = '{1'b0, 1'b0};
        m_sen_q = '{1'b0, 1'b0};
        reset          = 1'b1;
        bif.sample_en  = 1'b1;
        bif.btn_raw    = 1'b1;
        bif.sensor_raw = 1'b1;
        bif.walk_ack   = 1'b0;

        // reset with both raw inputs high
        run(2);
        chk("rst_sensor", int'(bif.sensor), 0);
        chk("rst_bw", int'(bif.button_walk), 0);
        chk("rst_press", int'(bif.btn_press), 0);
        reset = 1'b0;
        n = 0;
        while (n < 20 && bif.sensor !== 1'b1) begin
            tick();
            n++;
        end
        // 2 synchronizer edges, then DB_COUNT strobes
        chk("rst_sensor_latency", n, 2 + DBC);
        chk("rst_press_with_sensor", int'(bif.btn_press), 1);
        tick();
        chk("rst_bw_next", int'(bif.button_walk), 1);
        chk("rst_press_once", int'(bif.btn_press), 0);

        // glitch rejection
        bif.btn_raw = 1'b0;
        rst_pulse();
        run(10);
        n_press = 0;
        bw_seen = 0;
        bif.btn_raw = 1'b1;
        run(3);
        bif.btn_raw = 1'b0;
        run(2);
        bif.btn_raw = 1'b1;
        run(3);
        bif.btn_raw = 1'b0;
        run(12);
        chk("glitch_press", n_press, 0);
        chk("glitch_bw", bw_seen, 0);

        // clean press held for a long time, then ack
        n_press = 0;
        bif.btn_raw = 1'b1;
        run(25);
        chk("held_press_count", n_press, 1);
        chk("held_bw", int'(bif.button_walk), 1);
        bif.walk_ack = 1'b1;
        tick();
        bif.walk_ack = 1'b0;
        chk("ack_clears", int'(bif.button_walk), 0);
        run(10);
        chk("held_no_rearm", n_press, 1);
        chk("held_bw_low", int'(bif.button_walk), 0);

        // ack coincident with a second press while pending
        bif.btn_raw = 1'b0;
        run(10);
        bif.btn_raw = 1'b1;
        n = 0;
        while (n < 20 && bif.btn_press !== 1'b1) begin
            tick();
            n++;
        end
        chk("sim_press1_seen", int'(bif.btn_press), 1);
        tick();
        chk("sim_pending", int'(bif.button_walk), 1);
        bif.btn_raw = 1'b0;
        run(10);
        bif.btn_raw = 1'b1;
        n = 0;
        while (n < 20 && bif.btn_press !== 1'b1) begin
            tick();
            n++;
        end
        chk("sim_press2_seen", int'(bif.btn_press), 1);
        bif.walk_ack = 1'b1;
        tick();
        bif.walk_ack = 1'b0;
        chk("sim_rearm", int'(bif.button_walk), 1);
        run(3);
        chk("sim_still_pending", int'(bif.button_walk), 1);
        bif.walk_ack = 1'b1;
        tick();
        bif.walk_ack = 1'b0;
        chk("sim_lone_ack", int'(bif.button_walk), 0);

        // strobe pacing, clean step
        bif.btn_raw    = 1'b0;
        bif.sensor_raw = 1'b0;
        rst_pulse();
        bif.sample_en = 1'b0;
        strobe();
        bif.sensor_raw = 1'b1;
        run(9);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            strobe();
            if (first == 0 && bif.sensor === 1'b1) first = k;
            run(9);
        end
        chk("pace_clean", first, DBC);

        // strobe pacing, one-strobe dropout restarts the count
        bif.sensor_raw = 1'b0;
        rst_pulse();
        bif.sample_en = 1'b0;
        strobe();
        bif.sensor_raw = 1'b1;
        run(9);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            strobe();
            if (first == 0 && bif.sensor === 1'b1) first = k;
            if (k == 2) bif.sensor_raw = 1'b0;
            if (k == 3) bif.sensor_raw = 1'b1;
            run(9);
        end
        chk("pace_restart", first, 3 + DBC);

        // reset while pending and mid-count
        bif.sample_en  = 1'b1;
        bif.sensor_raw = 1'b0;
        bif.btn_raw    = 1'b1;
        rst_pulse();
        n = 0;
        while (n < 20 && bif.button_walk !== 1'b1) begin
            tick();
            n++;
        end
        chk("mid_pending", int'(bif.button_walk), 1);
        bif.sensor_raw = 1'b1;
        run(4);
        reset = 1'b1;
        tick();
        chk("mid_bw_dropped", int'(bif.button_walk), 0);
        chk("mid_sensor_low", int'(bif.sensor), 0);
        reset = 1'b0;
        n = 0;
        while (n < 20 && bif.sensor !== 1'b1) begin
            tick();
            n++;
        end
        chk("mid_full_recount", n, 2 + DBC);

        // randomized run against the model
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bif.btn_raw = ~bif.btn_raw;
            if ($urandom_range(0, 7) == 0) bif.sensor_raw = ~bif.sensor_raw;
            if (i < 2000) bif.sample_en = ($urandom_range(0, 2) != 0);
            else bif.sample_en = 1'b1;
            bif.walk_ack = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
            seen |= bif.button_walk;
        end
        reset        = 1'b0;
        bif.walk_ack = 1'b0;
        chk("rand_bw_exercised", int'(seen), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
